mram_bank_ctrl: RTL
===================

Name: mram_bank_ctrl

Overview:
Host-side access sequencer directly upstream of the MRAM bank macro. Accepts one read or write request at a time over a valid/ready interface and drives the bank pins (A, X, CEB, WEB, BEN, Din, Vclamp, DELAY_TRIM). It waits for the bank's WRC (write complete) or LAT (read data latched), captures OUT on reads, and returns a one-cycle response. A timeout guards against a bank that never completes.

Parameters:
BANK_DEPTH, 10, request address width; fixed split A=addr[9:8], X=addr[7:0]; values other than 10 unsupported
DATA_WIDTH, 32, data bits per word
ECC_WIDTH, 20, ECC bits per word
TOTAL_WIDTH, DATA_WIDTH+ECC_WIDTH (52), bank word width
BEN_WIDTH, 4, byte-enable width
TIMEOUT_CYCLES, 64, max ACCESS cycles before abort (>=2)
RECOVER_CYCLES, 2, CEB-high cycles after each access (>=1)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1=write, 0=read
req_addr  in  BANK_DEPTH  word address
req_wdata  in  TOTAL_WIDTH  write word (data+ECC)
req_ben  in  BEN_WIDTH  byte enables, passed to BEN unchanged
cfg_trim  in  2  sense-delay trim, latched at request accept
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  TOTAL_WIDTH  read word (0 for writes/timeouts)
rsp_err  out  1  1=timeout
A  out  2  bank column select
X  out  8  bank row select
CEB  out  1  chip enable, active low
WEB  out  1  write enable, active low
BEN  out  BEN_WIDTH  byte enables
Din  out  TOTAL_WIDTH  write data
Vclamp  out  1  read bitline clamp enable
DELAY_TRIM  out  2  sense-delay trim
OUT  in  TOTAL_WIDTH  bank read data
WRC  in  1  bank write complete
LAT  in  1  bank read data latched

Behaviour:
- All outputs registered. Reset values: CEB=1, WEB=1, A=0, X=0, BEN=0, Din=0, Vclamp=0, DELAY_TRIM=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 (state IDLE), counters 0.
- States: IDLE, SETUP, ACCESS, RECOVER.
- IDLE: req_ready=1. On req_valid&req_ready: latch we/addr/wdata/ben/cfg_trim; go SETUP. req_ready is 0 in every other state.
- SETUP (1 cycle): drive A, X, BEN, DELAY_TRIM, Din (=wdata for writes, 0 for reads), WEB=~we, Vclamp=~we; CEB stays 1. Go ACCESS.
- ACCESS: CEB=0, other pins held. Completion flag is WRC for writes, LAT for reads; the non-matching flag is ignored. Flags are sampled only in ACCESS. Flags in IDLE, SETUP and RECOVER are ignored.
  - Flag high: next cycle rsp_valid=1, rsp_err=0, rsp_rdata=OUT sampled on the flag cycle (reads) or 0 (writes). Go RECOVER.
  - ACCESS cycle count reaches TIMEOUT_CYCLES without the flag: next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0. Go RECOVER.
  - Flag on the timeout cycle itself counts as success.
- RECOVER: CEB=1, WEB=1, Vclamp=0. A/X/Din are held. Lasts RECOVER_CYCLES cycles, then go IDLE.
- rsp_valid is high exactly one cycle per accepted request. No response backpressure. rsp_rdata/rsp_err hold until the next response.
- Minimum latency: accept edge T. SETUP T+1. CEB low from T+2. If the flag is seen at T+2, rsp_valid is at T+3. req_ready returns at T+3+RECOVER_CYCLES.
- Reset mid-operation: next edge returns to IDLE with reset values (CEB=1). No response is issued for the aborted request.
- req_valid while busy is not accepted and is held by the host.

Test Plan:
1. Write addr=0x2A5, wdata=0xF_FFFF_DEAD_BEEF, ben=4'hF; bank pulses WRC on the 3rd ACCESS cycle -> A=2, X=0xA5, WEB=0 and CEB=0 for 3 cycles, then rsp_valid=1, rsp_err=0, rsp_rdata=0; req_ready=1 two cycles later.
2. Read addr=0x2A5; LAT in the 1st ACCESS cycle with OUT=0x0_1234_CAFE_F00D -> Vclamp=1 and WEB=1 during access; rsp_rdata=0x0_1234_CAFE_F00D at T+3.
3. Read with LAT never asserted -> CEB low exactly 64 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0; WRC pulses during the read are ignored.
4. Back-to-back: req_valid held with two requests (write then read) -> second accepted only after RECOVER; CEB high >=2 cycles between accesses; exactly two rsp_valid pulses.
5. RST asserted during ACCESS of a write -> CEB=1, WEB=1, req_ready=1 the next cycle; no rsp_valid; a subsequent read completes normally.
6. cfg_trim=2'b11 at accept, changed to 2'b00 mid-access -> DELAY_TRIM=2'b11 from SETUP through RECOVER.

Source files
------------

// File: rtl/mram_bank_ctrl.sv
// ---------------------------------------------------------------------------
// mram_bank_ctrl
//
// Host-side access sequencer sitting directly in front of one MRAM bank
// macro. It takes one read or write request at a time over a valid/ready
// handshake, walks the bank pins through SETUP -> ACCESS -> RECOVER, and
// returns a single-cycle response once the bank signals completion (WRC for
// writes, LAT for reads) or once the access has run too long.
//
// Ports
//   CLK, RST            clock (rising edge) and synchronous active-high reset
//   req_valid/req_ready request handshake; req_ready is high only in IDLE
//   req_we              1 = write, 0 = read
//   req_addr            word address, A = addr[9:8], X = addr[7:0]
//   req_wdata           write word (data + ECC)
//   req_ben             byte enables, forwarded to BEN unchanged
//   cfg_trim            sense-delay trim, captured when a request is accepted
//   rsp_valid           one-cycle response strobe, one per accepted request
//   rsp_rdata           read word (0 for writes and timeouts), held until next
//   rsp_err             1 = access timed out, held until next response
//   A, X, CEB, WEB, BEN, Din, Vclamp, DELAY_TRIM   bank macro pins
//   OUT, WRC, LAT       bank read data, write-complete, read-latched
//
// Every output is driven straight from a flop.
// ---------------------------------------------------------------------------
module mram_bank_ctrl #(
  parameter int BANK_DEPTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int ECC_WIDTH      = 20,
  parameter int TOTAL_WIDTH    = DATA_WIDTH + ECC_WIDTH,
  parameter int BEN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [BANK_DEPTH-1:0]  req_addr,
  input  logic [TOTAL_WIDTH-1:0] req_wdata,
  input  logic [BEN_WIDTH-1:0]   req_ben,
  input  logic [1:0]             cfg_trim,
  output logic                   rsp_valid,
  output logic [TOTAL_WIDTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic [1:0]             A,
  output logic [7:0]             X,
  output logic                   CEB,
  output logic                   WEB,
  output logic [BEN_WIDTH-1:0]   BEN,
  output logic [TOTAL_WIDTH-1:0] Din,
  output logic                   Vclamp,
  output logic [1:0]             DELAY_TRIM,
  input  logic [TOTAL_WIDTH-1:0] OUT,
  input  logic                   WRC,
  input  logic                   LAT
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RC_W = $clog2(RECOVER_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t                 state_r,     state_s;
  logic                   we_r,        we_s;
  logic [TO_W-1:0]        to_cnt_r,    to_cnt_s;
  logic [RC_W-1:0]        rc_cnt_r,    rc_cnt_s;
  logic                   req_ready_r, req_ready_s;
  logic [1:0]             a_r,         a_s;
  logic [7:0]             x_r,         x_s;
  logic                   ceb_r,       ceb_s;
  logic                   web_r,       web_s;
  logic [BEN_WIDTH-1:0]   ben_r,       ben_s;
  logic [TOTAL_WIDTH-1:0] din_r,       din_s;
  logic                   vclamp_r,    vclamp_s;
  logic [1:0]             trim_r,      trim_s;
  logic                   rsp_valid_r, rsp_valid_s;
  logic [TOTAL_WIDTH-1:0] rsp_rdata_r, rsp_rdata_s;
  logic                   rsp_err_r,   rsp_err_s;
  logic                   done_s;

  // Next-state and next-output logic; pins are computed one cycle ahead so
  // that every bank pin comes directly from a register.
  always_comb begin
    state_s     = state_r;
    we_s        = we_r;
    to_cnt_s    = to_cnt_r;
    rc_cnt_s    = rc_cnt_r;
    req_ready_s = req_ready_r;
    a_s         = a_r;
    x_s         = x_r;
    ceb_s       = ceb_r;
    web_s       = web_r;
    ben_s       = ben_r;
    din_s       = din_r;
    vclamp_s    = vclamp_r;
    trim_s      = trim_r;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = rsp_rdata_r;
    rsp_err_s   = rsp_err_r;
    // Only the flag matching the access direction can complete it.
    done_s      = we_r ? WRC : LAT;

    case (state_r)
      ST_IDLE: begin
        req_ready_s = 1'b1;
        if (req_valid && req_ready_r) begin
          // The pin registers double as the request latch: they load here
          // and are visible throughout the SETUP cycle.
          state_s     = ST_SETUP;
          req_ready_s = 1'b0;
          we_s        = req_we;
          a_s         = req_addr[9:8];
          x_s         = req_addr[7:0];
          ben_s       = req_ben;
          trim_s      = cfg_trim;
          din_s       = req_we ? req_wdata : {TOTAL_WIDTH{1'b0}};
          web_s       = ~req_we;
          vclamp_s    = ~req_we;
          ceb_s       = 1'b1;
        end else begin
          state_s     = ST_IDLE;
        end
      end

      ST_SETUP: begin
        state_s  = ST_ACCESS;
        ceb_s    = 1'b0;
        to_cnt_s = {TO_W{1'b0}};
      end

      ST_ACCESS: begin
        if (done_s) begin
          // Completion wins even on the last allowed cycle.
          state_s     = ST_RECOVER;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b0;
          rsp_rdata_s = we_r ? {TOTAL_WIDTH{1'b0}} : OUT;
          ceb_s       = 1'b1;
          web_s       = 1'b1;
          vclamp_s    = 1'b0;
          rc_cnt_s    = {RC_W{1'b0}};
        end else if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_s     = ST_RECOVER;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          rsp_rdata_s = {TOTAL_WIDTH{1'b0}};
          ceb_s       = 1'b1;
          web_s       = 1'b1;
          vclamp_s    = 1'b0;
          rc_cnt_s    = {RC_W{1'b0}};
        end else begin
          to_cnt_s    = to_cnt_r + TO_W'(1);
        end
      end

      ST_RECOVER: begin
        if (rc_cnt_r == RC_W'(RECOVER_CYCLES - 1)) begin
          state_s     = ST_IDLE;
          req_ready_s = 1'b1;
        end else begin
          rc_cnt_s    = rc_cnt_r + RC_W'(1);
        end
      end

      default: begin
        state_s     = ST_IDLE;
        req_ready_s = 1'b1;
        ceb_s       = 1'b1;
        web_s       = 1'b1;
        vclamp_s    = 1'b0;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      to_cnt_r    <= {TO_W{1'b0}};
      rc_cnt_r    <= {RC_W{1'b0}};
      req_ready_r <= 1'b1;
      a_r         <= 2'd0;
      x_r         <= 8'd0;
      ceb_r       <= 1'b1;
      web_r       <= 1'b1;
      ben_r       <= {BEN_WIDTH{1'b0}};
      din_r       <= {TOTAL_WIDTH{1'b0}};
      vclamp_r    <= 1'b0;
      trim_r      <= 2'd0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {TOTAL_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      we_r        <= we_s;
      to_cnt_r    <= to_cnt_s;
      rc_cnt_r    <= rc_cnt_s;
      req_ready_r <= req_ready_s;
      a_r         <= a_s;
      x_r         <= x_s;
      ceb_r       <= ceb_s;
      web_r       <= web_s;
      ben_r       <= ben_s;
      din_r       <= din_s;
      vclamp_r    <= vclamp_s;
      trim_r      <= trim_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign rsp_err    = rsp_err_r;
  assign A          = a_r;
  assign X          = x_r;
  assign CEB        = ceb_r;
  assign WEB        = web_r;
  assign BEN        = ben_r;
  assign Din        = din_r;
  assign Vclamp     = vclamp_r;
  assign DELAY_TRIM = trim_r;

endmodule
